// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer for the non-pipelined core.
//
// Owns the PC, issues one imem request per instruction over req/ack, holds
// the fetched word for decode/execute until retirement, then advances the PC
// (pc+4 or the redirect target with its low two bits cleared).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_req/addr       fetch request and address (addr always equals pc)
//   imem_ack/rdata      memory completion and returned word
//   instr_valid/instr/instr_pc   fetched instruction held for the core
//   instr_ready         core retires the held instruction this cycle
//   redirect/redirect_pc         control-flow change of the retiring instruction
//   fetch_fault         sticky fetch timeout flag
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   defined   : a REQ with no ack for TIMEOUT_CYCLES cycles enters FAULT,
//               which only rst leaves
//   undefined : REQ waits indefinitely, fetch_fault tied to 0
//
// state | meaning
// IDLE  | one cycle after reset, no request
// REQ   | request outstanding at pc, waiting for ack
// HOLD  | fetched instruction presented, waiting for retirement
// FAULT | fetch timed out, stuck until reset (FETCH_TIMEOUT_EN only)

module fetch_ctrl #(
  parameter int                       WORD_BITWIDTH  = 32,
  parameter logic [WORD_BITWIDTH-1:0] RESET_PC       = '0,
  parameter int                       TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [WORD_BITWIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [WORD_BITWIDTH-1:0] imem_rdata,
  output logic                     instr_valid,
  output logic [WORD_BITWIDTH-1:0] instr,
  output logic [WORD_BITWIDTH-1:0] instr_pc,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [WORD_BITWIDTH-1:0] redirect_pc,
  output logic                     fetch_fault
);

  localparam logic [WORD_BITWIDTH-1:0] ALIGN_MASK = ~WORD_BITWIDTH'(3);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
`ifdef FETCH_TIMEOUT_EN
    ,FAULT
`endif
  } state_t;

  state_t                   state, state_nxt;
  logic [WORD_BITWIDTH-1:0] pc, pc_nxt;
  logic                     capture;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Counts REQ cycles already spent without ack; the cycle in which it
  // equals CNT_LAST is the last one an ack can still rescue.
  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state != REQ) begin
      to_cnt <= '0;
    end else if (!imem_ack) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        // An ack on the final allowed cycle wins over the timeout.
        if (imem_ack) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (to_cnt == CNT_LAST) begin
          state_nxt = FAULT;
        end
`endif
      end
      HOLD: begin
        if (instr_ready) begin
          pc_nxt    = redirect ? (redirect_pc & ALIGN_MASK)
                               : pc + WORD_BITWIDTH'(4);
          state_nxt = REQ;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      FAULT: state_nxt = FAULT;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_req    = (state == REQ);
  assign instr_valid = (state == HOLD);
  assign imem_addr   = pc;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_fault = (state == FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int          W        = 32;
  localparam logic [31:0] RST_PC   = 32'h0;
  localparam int          TIMEOUT  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic          imem_ack;
  logic [W-1:0]  imem_rdata;
  logic          instr_valid;
  logic [W-1:0]  instr;
  logic [W-1:0]  instr_pc;
  logic          instr_ready;
  logic          redirect;
  logic [W-1:0]  redirect_pc;
  logic          fetch_fault;

  fetch_ctrl #(
    .WORD_BITWIDTH (W),
    .RESET_PC      (RST_PC),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard entries: {instruction word, fetch address}
  logic [2*W-1:0] sb_q[$];

  // Reference model state
  logic [W-1:0] model_pc;
  bit           in_req;
  int           wait_left;
  logic [W-1:0] req_addr;
  int           delay_q[$];
  bit           ready_always;
  bit           fault_phase = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
  endtask

  function automatic logic [W-1:0] pick_target();
    logic [W-1:0] t;
    case ($urandom_range(0, 3))
      0:       t = 32'h0000_0103;
      1:       t = 32'hFFFF_FFFC;
      2:       t = 32'hFFFF_FFFF;
      default: t = $urandom;
    endcase
    return t;
  endfunction

  // One cycle of memory + core behaviour, called at a negedge.
  task automatic drive_cycle();
    imem_ack    = 1'b0;
    imem_rdata  = $urandom;
    instr_ready = $urandom_range(0, 1);
    redirect    = $urandom_range(0, 1);
    redirect_pc = $urandom;
    if (imem_req) begin
      if (!in_req) begin
        in_req    = 1'b1;
        wait_left = (delay_q.size() > 0) ? delay_q.pop_front() : $urandom_range(0, 4);
        req_addr  = imem_addr;
        check("req_addr", imem_addr, model_pc);
      end else begin
        check("req_addr_stable", imem_addr, req_addr);
      end
      if (wait_left == 0) begin
        imem_ack = 1'b1;
        sb_q.push_back({imem_rdata, model_pc});
        in_req = 1'b0;
      end else begin
        wait_left--;
      end
    end else begin
      in_req   = 1'b0;
      imem_ack = ($urandom_range(0, 3) == 0);
      if (instr_valid) begin
        if (ready_always) begin
          instr_ready = 1'b1;
          redirect    = 1'b0;
        end else begin
          instr_ready = ($urandom_range(0, 2) != 0);
          if (instr_ready) redirect_pc = pick_target();
        end
        if (instr_ready)
          model_pc = redirect ? (redirect_pc & 32'hFFFF_FFFC) : model_pc + 32'd4;
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle_inputs();
    repeat (n) @(negedge clk);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_imem_addr", imem_addr, RST_PC);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);
    rst       = 1'b0;
    model_pc  = RST_PC;
    in_req    = 1'b0;
    sb_q.delete();
    delay_q.delete();
  endtask

  // Monitor: pops the scoreboard whenever a new instruction is presented.
  logic         prev_valid = 1'b0;
  logic [W-1:0] cur_instr, cur_pc;
  always @(negedge clk) begin
    if (instr_valid && imem_req) begin
      total++;
      bad++;
      $display("FAIL req_and_valid: both high at addr %h", imem_addr);
    end
    if (!fault_phase) begin
      total++;
      if (fetch_fault !== 1'b0) begin
        bad++;
        $display("FAIL fault_idle: got %b expected 0", fetch_fault);
      end
    end
    if (instr_valid && !prev_valid) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: instr %h pc %h presented with nothing expected", instr, instr_pc);
      end else begin
        {cur_instr, cur_pc} = sb_q.pop_front();
        if (instr !== cur_instr || instr_pc !== cur_pc) begin
          bad++;
          $display("FAIL sb_instr: got %h@%h expected %h@%h", instr, instr_pc, cur_instr, cur_pc);
        end
      end
    end else if (instr_valid) begin
      total++;
      if (instr !== cur_instr || instr_pc !== cur_pc) begin
        bad++;
        $display("FAIL hold_stable: got %h@%h expected %h@%h", instr, instr_pc, cur_instr, cur_pc);
      end
    end
    prev_valid = instr_valid;
  end

  initial begin
    int k;
    ready_always = 1'b1;
    @(negedge clk);
    do_reset(2);

    // Back-to-back fetches with zero ack latency, then a 3-cycle ack at 0x4.
    delay_q.push_back(0);
    delay_q.push_back(3);
    delay_q.push_back(0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive_cycle();
    end

    // Randomized traffic with redirects, wrap targets and stray inputs.
    ready_always = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      drive_cycle();
    end

    // Reset during an outstanding request, with a late ack afterwards.
    k = 0;
    @(negedge clk);
    while (!(imem_req && sb_q.size() == 0) && k < 40) begin
      drive_cycle();
      @(negedge clk);
      k++;
    end
    check("reach_req", {31'b0, imem_req}, 32'd1);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("midrst_req", {31'b0, imem_req}, 32'd0);
    check("midrst_valid", {31'b0, instr_valid}, 32'd0);
    check("midrst_addr", imem_addr, RST_PC);
    check("midrst_instr", instr, 32'd0);
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    model_pc   = RST_PC;
    in_req     = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("restart_req", {31'b0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, RST_PC);
    check("late_ack_ignored", instr, 32'd0);
    for (int i = 0; i < 200; i++) begin
      drive_cycle();
      @(negedge clk);
    end

`ifdef FETCH_TIMEOUT_EN
    // Ack on the final allowed REQ cycle still completes the fetch.
    do_reset(1);
    ready_always = 1'b1;
    delay_q.push_back(TIMEOUT - 1);
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      @(negedge clk);
      drive_cycle();
    end
    // No ack at all: fault after TIMEOUT REQ cycles, sticky until reset.
    do_reset(1);
    fault_phase = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      check("to_req_high", {31'b0, imem_req}, 32'd1);
      check("to_no_fault_yet", {31'b0, fetch_fault}, 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      imem_ack    = 1'b1;
      instr_ready = 1'b1;
      @(negedge clk);
      check("fault_set", {31'b0, fetch_fault}, 32'd1);
      check("fault_req_low", {31'b0, imem_req}, 32'd0);
      check("fault_valid_low", {31'b0, instr_valid}, 32'd0);
    end
    do_reset(1);
    fault_phase = 1'b0;
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencer for instruction fetch in the non-pipelined RISC-V core.
- Owns the program counter and issues one request per instruction to instruction memory over a req/ack handshake.
- Presents the fetched word to decode/execute and holds it until the core retires it.
- Takes the next-PC redirect (taken branch/jump) from execute at retirement.

Parameters:
- WORD_BITWIDTH, 32, width of PC, addresses and instruction words.
- RESET_PC, 0, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, cycles without ack before fault; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  WORD_BITWIDTH  fetch address, equals current PC.
- imem_ack  input  1  memory completes request; imem_rdata valid this cycle.
- imem_rdata  input  WORD_BITWIDTH  fetched instruction word.
- instr_valid  output  1  instr/instr_pc hold a fetched instruction.
- instr  output  WORD_BITWIDTH  fetched instruction.
- instr_pc  output  WORD_BITWIDTH  address the instruction was fetched from.
- instr_ready  input  1  core retires current instruction this cycle.
- redirect  input  1  retiring instruction changes control flow.
- redirect_pc  input  WORD_BITWIDTH  target PC when redirect=1.
- fetch_fault  output  1  sticky fetch timeout flag; constant 0 without FETCH_TIMEOUT_EN.

Behaviour:
- One clock (clk). Reset is synchronous and active-high on rst.
- Reset values: pc=RESET_PC; state=IDLE; imem_req=0; imem_addr=RESET_PC; instr_valid=0; instr=0; instr_pc=0; fetch_fault=0.
- Outputs are decoded from registered state only. There is no combinational path from any input to any output.
- imem_addr always equals pc.
- State IDLE (one cycle after reset):
  - imem_req=0, instr_valid=0.
  - Next state REQ unconditionally.
- State REQ:
  - imem_req=1, instr_valid=0.
  - imem_addr is stable and imem_req stays high until ack.
  - On imem_ack=1: instr<=imem_rdata, instr_pc<=pc, next state HOLD.
  - An ack in the first REQ cycle is accepted. Minimum latency is REQ at cycle t and instr_valid=1 at t+1.
- State HOLD:
  - imem_req=0, instr_valid=1, instr/instr_pc stable.
  - On instr_ready=1:
    - pc <= redirect ? {redirect_pc[W-1:2],2'b00} : pc+4.
    - Next state REQ.
  - Otherwise stay in HOLD.
- redirect/redirect_pc are sampled only in HOLD with instr_ready=1. They are ignored at all other times.
- PC arithmetic wraps modulo 2^WORD_BITWIDTH (0xFFFFFFFC+4 -> 0x00000000).
- Low two bits of a redirect target are forced to 0.
- imem_ack outside REQ is ignored. imem_rdata is not captured.
- instr_ready outside HOLD is ignored.
- Reset mid-operation (any state): next edge enters IDLE with reset values, imem_req drops. A late ack after reset is ignored.
- Steady state without stalls: one instruction per 2 cycles (REQ, HOLD).

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle with imem_ack=0.
  - When it reaches TIMEOUT_CYCLES without ack, next state is FAULT.
  - In FAULT: imem_req=0, instr_valid=0, fetch_fault=1 sticky; acks are ignored.
  - The only exit is rst.
  - An ack in the same cycle the count reaches the limit wins (HOLD, no fault).
- Not defined:
  - No counter and no FAULT state; REQ waits indefinitely.
  - fetch_fault is tied to 0.

Test Plan:
- Reset, memory acks in first REQ cycle, instr_ready=1 whenever instr_valid -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid high every second cycle; instr_pc matches address.
- Ack delayed 3 cycles at address 0x4 -> imem_req high 4 cycles with imem_addr=0x4 stable; instr=rdata captured on ack cycle; instr_pc=0x4.
- HOLD with instr_ready=1, redirect=1, redirect_pc=0x103 -> next imem_addr=0x100; redirect=1 while instr_ready=0 -> ignored, PC unchanged.
- pc=0xFFFFFFFC retired without redirect -> next imem_addr=0x00000000.
- rst asserted during REQ at 0x8, ack arrives the cycle after -> imem_req=0, state IDLE, then fetch restarts at RESET_PC; late ack not captured.
- FETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no ack -> fetch_fault=1 after 16 REQ cycles, imem_req=0 and stays until rst. Ack on cycle 16 -> no fault, instr_valid=1.
